// File: rtl/verdict_pkg.sv
// verdict_collector shared types and constants.
// Record layout and default sizes for the verdict capture path.
package verdict_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_TS_W   = 32;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_DROP_W = 16;

  localparam int REC_W    = DEF_TS_W + 2 + 2 * DEF_DATA_W;
  localparam int V0_LSB   = 0;
  localparam int V1_LSB   = DEF_DATA_W;
  localparam int AKTV_LSB = 2 * DEF_DATA_W;
  localparam int TS_LSB   = 2 * DEF_DATA_W + 2;

  typedef struct packed {
    logic [DEF_TS_W-1:0]          ts;
    logic [1:0]                   aktv;
    logic signed [DEF_DATA_W-1:0] value1;
    logic signed [DEF_DATA_W-1:0] value0;
  } record_t;

  function automatic int rec_w(input int dw, input int tw);
    return tw + 2 + 2 * dw;
  endfunction

endpackage

// File: rtl/verdict_collector_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO, one clock.
// Accepts a write when full if a read happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_rd;
  logic             do_wr;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];
  assign level   = count;

  // storage write; contents need no reset since empty masks rd_data
  always_ff @(posedge clk) begin
    if (do_wr && !rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/verdict_collector.sv
// verdict_collector: timestamps active monitor verdicts
// and queues them for a valid/ready consumer.
module verdict_collector
  import verdict_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TS_W   = DEF_TS_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DROP_W = DEF_DROP_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DATA_W-1:0]             output_0,
  input  logic                          output_0_aktv,
  input  logic [DATA_W-1:0]             output_1,
  input  logic                          output_1_aktv,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [rec_w(DATA_W,TS_W)-1:0] m_data,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          overflow,
  output logic [DROP_W-1:0]             drop_count
);

  localparam int RW = rec_w(DATA_W, TS_W);

  logic [TS_W-1:0] ts;
  logic [RW-1:0]   rec;
  logic            capture;
  logic            pop;
  logic            full;
  logic            empty;
  logic            drop;

  assign capture = en & (output_0_aktv | output_1_aktv);
  assign pop     = m_valid & m_ready;
  assign drop    = capture & full & ~pop;
  assign m_valid = ~empty;

  // inactive outputs are zeroed so stale bus values never leak
  assign rec = {ts,
                output_1_aktv, output_0_aktv,
                output_1 & {DATA_W{output_1_aktv}},
                output_0 & {DATA_W{output_0_aktv}}};

  // free-running cycle stamp, frozen while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      ts <= '0;
    end else if (en) begin
      ts <= ts + 1'b1;
    end
  end

  // sticky overflow and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (capture),
    .wr_data (rec),
    .rd_en   (m_ready),
    .rd_data (m_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

endmodule

// File: tb/tb_verdict_collector.sv
// tb_verdict_collector: directed checks of capture,
// backpressure, overflow, enable gating and reset.
module tb_verdict_collector;
  import verdict_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [63:0]      output_0;
  logic             output_0_aktv;
  logic [63:0]      output_1;
  logic             output_1_aktv;
  logic             m_valid;
  logic             m_ready;
  logic [REC_W-1:0] m_data;
  logic [4:0]       level;
  logic             overflow;
  logic [15:0]      drop_count;

  int n_run  = 0;
  int n_fail = 0;

  record_t r;
  assign r = record_t'(m_data);

  verdict_collector dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .output_0      (output_0),
    .output_0_aktv (output_0_aktv),
    .output_1      (output_1),
    .output_1_aktv (output_1_aktv),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .level         (level),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag,
                     input logic [191:0] got,
                     input logic [191:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [REC_W-1:0] exp_rec;
    rst = 1'b1; en = 1'b0; m_ready = 1'b0;
    output_0 = '0; output_1 = '0;
    output_0_aktv = 1'b0; output_1_aktv = 1'b0;
    ticks(2);
    rst = 1'b0;

    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drops", drop_count, 0);

    // single event at ts=500, output_1 inactive with junk
    en = 1'b1; m_ready = 1'b1;
    ticks(500);
    output_0 = 64'd1; output_1 = 64'h55;
    output_0_aktv = 1'b1;
    chk("single_pre_valid", m_valid, 0);
    tick();
    output_0_aktv = 1'b0;
    exp_rec = {32'd500, 2'b01, 64'd0, 64'd1};
    chk("single_valid", m_valid, 1);
    chk("single_rec", m_data, exp_rec);
    chk("single_level", level, 1);
    tick();
    chk("single_popped", m_valid, 0);
    chk("single_level0", level, 0);

    // both outputs active at ts=10
    do_reset();
    ticks(10);
    output_0 = -64'sd3; output_1 = 64'd7;
    output_0_aktv = 1'b1; output_1_aktv = 1'b1;
    tick();
    output_0_aktv = 1'b0; output_1_aktv = 1'b0;
    exp_rec = {32'd10, 2'b11, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD};
    chk("both_rec", m_data, exp_rec);
    tick();
    chk("both_popped", m_valid, 0);

    // backpressure: 19 captures into 16 slots
    m_ready = 1'b0;
    output_0_aktv = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      output_0 = 64'(i);
      tick();
    end
    output_0_aktv = 1'b0;
    chk("bp_level", level, 16);
    chk("bp_ovf", overflow, 1);
    chk("bp_drops", drop_count, 3);
    chk("bp_head", r.value0, 1);
    tick();
    chk("bp_hold", r.value0, 1);

    // full with simultaneous pop: 99 accepted, no drop
    output_0 = 64'd99; output_0_aktv = 1'b1;
    m_ready = 1'b1;
    chk("fullpop_head", r.value0, 1);
    tick();
    output_0_aktv = 1'b0;
    chk("fullpop_level", level, 16);
    chk("fullpop_drops", drop_count, 3);
    for (int i = 2; i <= 16; i++) begin
      chk($sformatf("drain_%0d", i), r.value0, 64'(i));
      tick();
    end
    chk("drain_99", r.value0, 99);
    chk("drain_99_aktv", r.aktv, 2'b01);
    tick();
    chk("drain_empty", m_valid, 0);
    chk("drain_level", level, 0);

    // enable gating
    do_reset();
    chk("rerst_ovf", overflow, 0);
    ticks(5);
    m_ready = 1'b0;
    output_0 = 64'd42; output_1 = 64'd43;
    output_0_aktv = 1'b1;
    tick();
    chk("gate_rec_ts", r.ts, 5);
    en = 1'b0; output_1_aktv = 1'b1;
    ticks(50);
    chk("gate_nocap", level, 1);
    chk("gate_hold", r.value0, 42);
    m_ready = 1'b1;
    tick();
    chk("gate_drained", m_valid, 0);
    ticks(49);
    chk("gate_nocap2", level, 0);
    m_ready = 1'b0; output_1_aktv = 1'b0;
    en = 1'b1;
    tick();
    chk("gate_resume_ts", r.ts, 6);
    chk("gate_resume_lvl", level, 1);

    // reset mid-stream with level=5
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    chk("mid_level", level, 5);
    chk("mid_valid", m_valid, 1);
    rst = 1'b1; m_ready = 1'b1;
    tick();
    rst = 1'b0; m_ready = 1'b0;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_drops", drop_count, 0);
    tick();
    chk("mid_ts0", r.ts, 0);
    chk("mid_level1", level, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/verdict_collector.md
# verdict_collector

Captures the verdict stream produced by the compiled RTLola monitor (`topEntity`). For every cycle in which at least one output stream is active, it records the output values, the activity mask and a cycle timestamp into a FIFO, and presents those records to a downstream consumer over a valid/ready stream. It sits directly behind the monitor and is the hardware counterpart of the stimulus side that drives `input_N`/`new_input_N`.

## Interface
Parameters:
- `DATA_W`, 64: width of each monitor output (signed).
- `TS_W`, 32: timestamp counter width.
- `DEPTH`, 16: FIFO depth in records; a power of two, ≥2.
- `DROP_W`, 16: width of the dropped-record counter.

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `en`  in  1  enable for timestamping and capture.
- `output_0`  in  DATA_W  monitor output 0 (signed).
- `output_0_aktv`  in  1  output 0 active this cycle.
- `output_1`  in  DATA_W  monitor output 1 (signed).
- `output_1_aktv`  in  1  output 1 active this cycle.
- `m_valid`  out  1  a record is available.
- `m_ready`  in  1  the consumer accepts the record.
- `m_data`  out  TS_W+2+2·DATA_W  record, MSB→LSB: {timestamp, aktv[1:0], value1, value0}.
- `level`  out  clog2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky; set when any record has been dropped.
- `drop_count`  out  DROP_W  number of dropped records; saturates at its maximum.

## Operation
- **Timestamp counter.**
  - `ts` increments by 1 on every cycle in which `en`=1.
  - Wraps modulo 2^TS_W, with no flag on wrap.
  - Frozen while `en`=0.
- **Capture condition.** A capture happens when `en`=1 and (`output_0_aktv` | `output_1_aktv`).
- **Captured record.**
  - The timestamp field is the `ts` value *before* that cycle's increment.
  - `aktv` = {`output_1_aktv`, `output_0_aktv`}.
  - The value of an inactive output is stored as 0, never its raw bus value.
- **Push rule.** The record is pushed if `level` < DEPTH, or if `level` = DEPTH and a pop (`m_valid` & `m_ready`) occurs in the same cycle.
- **Drop rule.**
  - If the record is not pushed, it is dropped.
  - `overflow` is set to 1 and `drop_count` increments, saturating at 2^DROP_W−1.
- **Pop rule.**
  - A pop happens on `m_valid` & `m_ready`.
  - `m_data` must hold stable while `m_valid`=1 and `m_ready`=0.
- **Readout and `en`.** Readout is independent of `en`; draining continues while `en`=0.
- **Ordering.** Records leave strictly in capture order.
- **Reset** (`rst`=1 at an edge):
  - Clears the FIFO, `ts`, `overflow` and `drop_count`.
  - Takes priority over a simultaneous capture or pop.
  - A record being presented at that moment is discarded.

## Timing
- **Output values after reset:** `m_valid`=0, `m_data`=0, `level`=0, `overflow`=0, `drop_count`=0; the first timestamp is 0.
- **Capture latency.** A record captured on edge *k* is visible on `m_valid`/`m_data` after edge *k* if the FIFO was empty, i.e. one cycle of latency. The FIFO is first-word-fall-through, with no extra read cycle.
- **Throughput.** One push and one pop per cycle.
- **Simultaneous push and pop.**
  - With `level` = 0: the record is pushed; `m_valid` rises next cycle.
  - With 0 < `level` < DEPTH: `level` is unchanged.
  - With `level` = DEPTH: the push is accepted and `level` stays at DEPTH.
- **`level`** is registered and reflects pushes and pops from the previous edge.
- **`overflow` and `drop_count`** update on the edge of the dropping capture.

## Structure
- **Package `verdict_pkg`:**
  - `record_t` packed struct {ts, aktv, value1, value0}.
  - Field offsets and `REC_W` = TS_W+2+2·DATA_W.
  - Default parameter constants.
- **Sub-module `sync_fifo`:**
  - Parameterised width and depth, first-word-fall-through, one clock, synchronous reset.
  - Exposes `full`, `empty` and `level`, and supports simultaneous read and write when full.
- **Top level:** `verdict_collector` holds the timestamp counter, record packing, the drop logic, and the `sync_fifo` instance.

## Test plan
- **Reset then a single event.** After `rst` is released, hold `en`=1 and at ts=500 pulse `output_0_aktv` with `output_0`=1 and `output_1`=0x55 (inactive), with `m_ready`=1. Required: one record {ts=500, aktv=01, v1=0, v0=1}, appearing one cycle later.
- **Both outputs active.** Drive `output_0`=−3 and `output_1`=7, both active, at ts=10. Required: `m_data` = {10, 11, 7, −3 as two's complement}.
- **Backpressure and overflow.** With `m_ready`=0, capture DEPTH+3 events on consecutive cycles (values 1…19). Required:
  - `level`=16, `overflow`=1, `drop_count`=3.
  - Draining yields values 1…16 in order.
- **Full with simultaneous pop.** At `level`=DEPTH, capture value 99 in the same cycle as a pop. Required:
  - No drop; `level` stays at DEPTH.
  - 99 is read out last.
- **Enable gating.** Drop `en` for 100 cycles with outputs active throughout, then raise it. Required:
  - No records captured while `en`=0.
  - `ts` is frozen while `en`=0 and resumes from its held value.
  - A pending record still drains while `en`=0.
- **Reset mid-stream.** With `level`=5 and `m_valid`=1, assert `rst` for one cycle. Required: the next cycle shows `m_valid`=0, `level`=0, `drop_count`=0, and the next capture is stamped ts=0.
